// File: rtl/skip_count_monitor_pkg.sv
// Shared definitions for the skip counter and its monitor: state enum,
// code constants, successor and ordinal decode helpers.
package skip_count_monitor_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } mon_state_t;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;
  localparam logic [2:0] S7 = 3'd7;

  localparam logic [2:0] ORD_ILLEGAL = 3'd7;

  // Next code in the 0,1,2,4,5,6 cycle. Codes 3/7 have no successor; they
  // map to S0 but are never compared against, since exp is always legal.
  function automatic logic [2:0] skip_succ(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S4;
      S4:      nxt = S5;
      S5:      nxt = S6;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // Position of a code within the period; illegal codes decode to 7.
  function automatic logic [2:0] skip_ordinal(input logic [2:0] code);
    logic [2:0] ord;
    case (code)
      S0:      ord = 3'd0;
      S1:      ord = 3'd1;
      S2:      ord = 3'd2;
      S4:      ord = 3'd3;
      S5:      ord = 3'd4;
      S6:      ord = 3'd5;
      default: ord = ORD_ILLEGAL;
    endcase
    return ord;
  endfunction

  function automatic logic skip_illegal(input logic [2:0] code);
    return (code == S3) || (code == S7);
  endfunction

endpackage

// File: rtl/skip_count_monitor.sv
// Receive-side checker for the skip counter: locks onto the 0,1,2,4,5,6
// sequence, decodes ordinals, flags illegal codes and sequence errors, and
// counts completed periods and errors. All outputs are registered.
module skip_count_monitor
  import skip_count_monitor_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       a_in,
  input  logic             clear,
  output logic             locked,
  output logic [2:0]       ordinal,
  output logic             illegal,
  output logic             seq_err,
  output logic [CNT_W-1:0] period_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_t       state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       ordinal_q, ordinal_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [ERR_W-1:0] err_q, err_d;

  // Register all state; reset returns to HUNT expecting code 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      exp_q     <= S1;
      ordinal_q <= 3'd0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
      period_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      ordinal_q <= ordinal_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
      period_q  <= period_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: clear beats any sample; pulses default low each cycle.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    ordinal_d = ordinal_q;
    illegal_d = 1'b0;
    seq_err_d = 1'b0;
    period_d  = period_q;
    err_d     = err_q;

    if (clear) begin
      state_d  = HUNT;
      exp_d    = S1;
      period_d = '0;
      err_d    = '0;
    end else if (in_valid) begin
      ordinal_d = skip_ordinal(a_in);
      illegal_d = skip_illegal(a_in);
      case (state_q)
        HUNT: begin
          if (a_in == S0) begin
            state_d = LOCKED;
            exp_d   = S1;
          end
        end
        LOCKED: begin
          if (a_in == exp_q) begin
            exp_d = skip_succ(a_in);
            if (a_in == S0) begin
              period_d = period_q + CNT_ONE;
            end
          end else begin
            seq_err_d = 1'b1;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
            // A stray 0 is still a valid period start, so relock on it.
            exp_d = S1;
            if (a_in != S0) begin
              state_d = HUNT;
            end
          end
        end
        default: begin
          state_d = HUNT;
          exp_d   = S1;
        end
      endcase
    end
  end

  assign locked     = (state_q == LOCKED);
  assign ordinal    = ordinal_q;
  assign illegal    = illegal_q;
  assign seq_err    = seq_err_q;
  assign period_cnt = period_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_skip_count_monitor.sv
// Bench for skip_count_monitor: directed table, saturation sequence on a
// narrow-error-counter build, and randomized traffic against a model.
module tb_skip_count_monitor;

  logic       clk = 1'b0;
  logic       reset, in_valid, clear;
  logic [2:0] a_in;

  logic       locked, locked2;
  logic [2:0] ordinal, ordinal2;
  logic       illegal, illegal2, seq_err, seq_err2;
  logic [7:0] period_cnt, period_cnt2;
  logic [3:0] err_cnt;
  logic [1:0] err_cnt2;

  skip_count_monitor #(.CNT_W(8), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_in(a_in), .clear(clear),
    .locked(locked), .ordinal(ordinal), .illegal(illegal), .seq_err(seq_err),
    .period_cnt(period_cnt), .err_cnt(err_cnt)
  );

  skip_count_monitor #(.CNT_W(8), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a_in(a_in), .clear(clear),
    .locked(locked2), .ordinal(ordinal2), .illegal(illegal2), .seq_err(seq_err2),
    .period_cnt(period_cnt2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the period list, not an expected code.
  int seq_list[6] = '{0, 1, 2, 4, 5, 6};
  bit m_locked;
  int m_pos, m_ord, m_per, m_err, m_err2;
  bit m_ill, m_seq;

  function automatic int ord_of(int code);
    for (int i = 0; i < 6; i++) if (seq_list[i] == code) return i;
    return 7;
  endfunction

  function automatic int next_code();
    return m_locked ? seq_list[(m_pos + 1) % 6] : 0;
  endfunction

  task automatic model_update(bit r, bit c, bit v, int a);
    if (r) begin
      m_locked = 0; m_pos = 0; m_ord = 0; m_ill = 0; m_seq = 0;
      m_per = 0; m_err = 0; m_err2 = 0;
    end else if (c) begin
      m_locked = 0; m_ill = 0; m_seq = 0; m_per = 0; m_err = 0; m_err2 = 0;
    end else if (v) begin
      m_ill = (a == 3) || (a == 7);
      m_ord = ord_of(a);
      m_seq = 0;
      if (!m_locked) begin
        if (a == 0) begin m_locked = 1; m_pos = 0; end
      end else if (a == seq_list[(m_pos + 1) % 6]) begin
        m_pos = (m_pos + 1) % 6;
        if (m_pos == 0) m_per = (m_per + 1) % 256;
      end else begin
        m_seq = 1;
        if (m_err < 15) m_err++;
        if (m_err2 < 3) m_err2++;
        if (a == 0) m_pos = 0;
        else m_locked = 0;
      end
    end else begin
      m_ill = 0; m_seq = 0;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge, advance the model at the rising edge.
  task automatic step(bit r, bit c, bit v, logic [2:0] a);
    @(negedge clk);
    reset = r; clear = c; in_valid = v; a_in = a;
    @(posedge clk);
    model_update(r, c, v, int'(a));
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".locked"},  int'(locked),     int'(m_locked));
    chk({tag, ".ordinal"}, int'(ordinal),    m_ord);
    chk({tag, ".illegal"}, int'(illegal),    int'(m_ill));
    chk({tag, ".seq_err"}, int'(seq_err),    int'(m_seq));
    chk({tag, ".period"},  int'(period_cnt), m_per);
    chk({tag, ".err"},     int'(err_cnt),    m_err);
    chk({tag, ".err2"},    int'(err_cnt2),   m_err2);
  endtask

  typedef struct {
    bit r; bit c; bit v; logic [2:0] a;
    int lk; int ord; int ill; int se; int per; int err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit c, bit v, int a,
                              int lk, int ord, int ill, int se, int per, int err);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.a = 3'(a);
    t.lk = lk; t.ord = ord; t.ill = ill; t.se = se; t.per = per; t.err = err;
    return t;
  endfunction

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; a_in = 3'd0;

    // Directed table: hunting, illegal code, 0-relock, idle hold, wrap, clear, reset.
    //            r  c  v  a    lk ord il se per err
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5,  0, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6,  0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3,  0, 7, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 7,  0, 7, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 2,  1, 2, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 4,  1, 3, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 6,  1, 3, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 3,  1, 3, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 5,  1, 4, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 6,  1, 5, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 1, 2,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].a);
      $display("vec %0d: r=%0b c=%0b v=%0b a=%0d -> locked=%0b ord=%0d ill=%0b se=%0b per=%0d err=%0d",
               i, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].a, locked, ordinal, illegal,
               seq_err, period_cnt, err_cnt);
      chk($sformatf("t%0d.locked", i),  int'(locked),     tbl[i].lk);
      chk($sformatf("t%0d.ordinal", i), int'(ordinal),    tbl[i].ord);
      chk($sformatf("t%0d.illegal", i), int'(illegal),    tbl[i].ill);
      chk($sformatf("t%0d.seq_err", i), int'(seq_err),    tbl[i].se);
      chk($sformatf("t%0d.period", i),  int'(period_cnt), tbl[i].per);
      chk($sformatf("t%0d.err", i),     int'(err_cnt),    tbl[i].err);
    end

    // Three full periods then 0: three completed wraps, no errors.
    step(1, 0, 0, 3'd0);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 6; k++) begin
        step(0, 0, 1, 3'(seq_list[k]));
        chk_model($sformatf("run.p%0d.k%0d", p, k));
      end
    step(0, 0, 1, 3'd0);
    $display("run: locked=%0b period=%0d err=%0d", locked, period_cnt, err_cnt);
    chk("run.period_final", int'(period_cnt), 3);
    chk("run.err_final", int'(err_cnt), 0);

    // Repeated stray 0s while locked: each is a mismatch; narrow counter saturates.
    step(1, 0, 0, 3'd0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 3'd0);
    $display("sat: err=%0d err2=%0d locked=%0b", err_cnt, err_cnt2, locked);
    chk("sat.err_wide", int'(err_cnt), 5);
    chk("sat.err_narrow", int'(err_cnt2), 3);
    chk("sat.locked", int'(locked), 1);
    chk_model("sat");

    // Randomized traffic, mostly in-sequence codes with occasional faults.
    step(1, 0, 0, 3'd0);
    for (int n = 0; n < 3000; n++) begin
      bit r, c, v;
      logic [2:0] a;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 8);
      a = ($urandom_range(0, 9) < 8) ? 3'(next_code()) : 3'($urandom_range(0, 7));
      step(r, c, v, a);
      chk_model($sformatf("rnd%0d", n));
      if (n % 250 == 0)
        $display("rnd %0d: r=%0b c=%0b v=%0b a=%0d -> locked=%0b ord=%0d per=%0d err=%0d",
                 n, r, c, v, a, locked, ordinal, period_cnt, err_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
